// File: rtl/tlb_entry_ctrl.sv
// rtl/tlb_entry_ctrl.sv - four-entry TLB storage with lookup, refill, flush and counter aging
module tlb_entry_ctrl #(
   parameter int VPN_W      = 27,
   parameter int PPN_W      = 44,
   parameter int CNT_W      = 12,
   parameter int AGE_PERIOD = 1024,
   parameter int INIT_CNT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lookup_valid,
   input  logic [VPN_W-1:0] lookup_vpn,
   output logic             hit,
   output logic             miss,
   output logic [PPN_W-1:0] hit_ppn,
   output logic [7:0]       hit_flags,
   input  logic             refill_valid,
   input  logic [VPN_W-1:0] refill_vpn,
   input  logic [PPN_W-1:0] refill_ppn,
   input  logic [7:0]       refill_flags,
   output logic             refill_done,
   input  logic [3:0]       entry_select,
   input  logic             flush_valid,
   input  logic             flush_all,
   input  logic [VPN_W-1:0] flush_vpn,
   output logic             flush_done,
   output logic             entry0_valid,
   output logic [CNT_W-1:0] entry0_acc_count,
   output logic             entry0_PTE_G,
   output logic             entry1_valid,
   output logic [CNT_W-1:0] entry1_acc_count,
   output logic             entry1_PTE_G,
   output logic             entry2_valid,
   output logic [CNT_W-1:0] entry2_acc_count,
   output logic             entry2_PTE_G,
   output logic             entry3_valid,
   output logic [CNT_W-1:0] entry3_acc_count,
   output logic             entry3_PTE_G
);

   localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [VPN_W-1:0] vpn_q   [4];
   logic [PPN_W-1:0] ppn_q   [4];
   logic [7:0]       flags_q [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_next[4];
   logic [3:0]       valid_q;
   logic [AGE_W-1:0] age_q;

   logic [3:0]       lk_match;
   logic [3:0]       rf_match;
   logic [3:0]       rf_cand;
   logic [3:0]       fl_match;
   logic [1:0]       rf_idx;
   logic             aging;
   logic [PPN_W-1:0] lk_ppn;
   logic [7:0]       lk_flags;

   // All matching uses pre-update state so lookups never observe same-cycle writes.
   always_comb begin
      aging    = (age_q == AGE_W'(AGE_PERIOD - 1));
      lk_ppn   = '0;
      lk_flags = '0;
      rf_idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         lk_match[i] = lookup_valid && valid_q[i] && (vpn_q[i] == lookup_vpn);
         rf_match[i] = valid_q[i] && (vpn_q[i] == refill_vpn);
         fl_match[i] = flush_valid && (flush_all || (vpn_q[i] == flush_vpn));
         if (lk_match[i]) begin
            lk_ppn   = lk_ppn | ppn_q[i];
            lk_flags = lk_flags | flags_q[i];
         end
         cnt_next[i] = aging ? (cnt_q[i] >> 1) : cnt_q[i];
         if (lk_match[i] && (cnt_next[i] != CNT_MAX))
            cnt_next[i] = cnt_next[i] + CNT_W'(1);
      end
      // An existing translation for the VPN beats the selector's victim choice.
      rf_cand = (|rf_match) ? rf_match : entry_select;
      for (int i = 3; i >= 0; i--)
         if (rf_cand[i]) rf_idx = 2'(i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            vpn_q[i]   <= '0;
            ppn_q[i]   <= '0;
            flags_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
         valid_q     <= '0;
         age_q       <= '0;
         hit         <= 1'b0;
         miss        <= 1'b0;
         hit_ppn     <= '0;
         hit_flags   <= '0;
         refill_done <= 1'b0;
         flush_done  <= 1'b0;
      end else begin
         age_q       <= aging ? '0 : age_q + AGE_W'(1);
         hit         <= |lk_match;
         miss        <= lookup_valid && !(|lk_match);
         hit_ppn     <= lk_ppn;
         hit_flags   <= lk_flags;
         refill_done <= refill_valid;
         flush_done  <= flush_valid;
         for (int i = 0; i < 4; i++) begin
            if (refill_valid && (rf_idx == 2'(i))) begin
               vpn_q[i]   <= refill_vpn;
               ppn_q[i]   <= refill_ppn;
               flags_q[i] <= refill_flags;
               cnt_q[i]   <= CNT_W'(INIT_CNT);
               valid_q[i] <= 1'b1;
            end else begin
               cnt_q[i] <= cnt_next[i];
            end
            if (fl_match[i]) valid_q[i] <= 1'b0;
         end
      end
   end

   assign entry0_valid     = valid_q[0];
   assign entry1_valid     = valid_q[1];
   assign entry2_valid     = valid_q[2];
   assign entry3_valid     = valid_q[3];
   assign entry0_acc_count = cnt_q[0];
   assign entry1_acc_count = cnt_q[1];
   assign entry2_acc_count = cnt_q[2];
   assign entry3_acc_count = cnt_q[3];
   assign entry0_PTE_G     = flags_q[0][5];
   assign entry1_PTE_G     = flags_q[1][5];
   assign entry2_PTE_G     = flags_q[2][5];
   assign entry3_PTE_G     = flags_q[3][5];

endmodule

// File: tb/tb_tlb_entry_ctrl.sv
// tb/tb_tlb_entry_ctrl.sv - scoreboard bench for tlb_entry_ctrl
module tb_tlb_entry_ctrl;
   localparam int VPN_W = 27, PPN_W = 44, CNT_W = 12, INIT_CNT = 1;
   localparam int AGE_PERIOD = 8192;
   localparam int CMAX = 4095;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, lookup_valid, refill_valid, flush_valid, flush_all;
   logic [VPN_W-1:0] lookup_vpn, refill_vpn, flush_vpn;
   logic [PPN_W-1:0] refill_ppn, hit_ppn;
   logic [7:0] refill_flags, hit_flags;
   logic [3:0] entry_select;
   logic hit, miss, refill_done, flush_done;
   logic e0_v, e1_v, e2_v, e3_v, e0_g, e1_g, e2_g, e3_g;
   logic [CNT_W-1:0] e0_c, e1_c, e2_c, e3_c;

   tlb_entry_ctrl #(.VPN_W(VPN_W), .PPN_W(PPN_W), .CNT_W(CNT_W),
                    .AGE_PERIOD(AGE_PERIOD), .INIT_CNT(INIT_CNT)) dut (
      .clk(clk), .rst_n(rst_n),
      .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn),
      .hit(hit), .miss(miss), .hit_ppn(hit_ppn), .hit_flags(hit_flags),
      .refill_valid(refill_valid), .refill_vpn(refill_vpn), .refill_ppn(refill_ppn),
      .refill_flags(refill_flags), .refill_done(refill_done), .entry_select(entry_select),
      .flush_valid(flush_valid), .flush_all(flush_all), .flush_vpn(flush_vpn),
      .flush_done(flush_done),
      .entry0_valid(e0_v), .entry0_acc_count(e0_c), .entry0_PTE_G(e0_g),
      .entry1_valid(e1_v), .entry1_acc_count(e1_c), .entry1_PTE_G(e1_g),
      .entry2_valid(e2_v), .entry2_acc_count(e2_c), .entry2_PTE_G(e2_g),
      .entry3_valid(e3_v), .entry3_acc_count(e3_c), .entry3_PTE_G(e3_g)
   );

   typedef struct {
      logic hit; logic miss; logic [PPN_W-1:0] ppn; logic [7:0] flags;
      logic rdone; logic fdone;
   } resp_t;
   resp_t exp_q[$];
   int errors = 0, checks = 0;

   // reference model: one record per entry, plain integers for counts
   logic             m_valid[4];
   logic [VPN_W-1:0] m_vpn[4];
   logic [PPN_W-1:0] m_ppn[4];
   logic [7:0]       m_flags[4];
   int               m_cnt[4];
   int               m_cycles;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0; m_vpn[i] = '0; m_ppn[i] = '0; m_flags[i] = '0; m_cnt[i] = 0;
      end
      m_cycles = 0;
   endtask

   task automatic check_entries();
      logic [3:0] v; logic [3:0] g; logic [CNT_W-1:0] c[4];
      v = {e3_v, e2_v, e1_v, e0_v};
      g = {e3_g, e2_g, e1_g, e0_g};
      c[0] = e0_c; c[1] = e1_c; c[2] = e2_c; c[3] = e3_c;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("entry%0d_valid", i), 64'(v[i]), 64'(m_valid[i]));
         chk($sformatf("entry%0d_acc_count", i), 64'(c[i]), 64'(m_cnt[i]));
         chk($sformatf("entry%0d_PTE_G", i), 64'(g[i]), 64'(m_flags[i][5]));
      end
   endtask

   // Called at a falling edge: drive one cycle, predict, advance, check entries.
   task automatic step(input logic lv, input logic [VPN_W-1:0] lvpn,
                       input logic rv, input logic [VPN_W-1:0] rvpn,
                       input logic [PPN_W-1:0] rppn, input logic [7:0] rfl,
                       input logic [3:0] sel, input logic fv, input logic fa,
                       input logic [VPN_W-1:0] fvpn);
      resp_t e;
      int hi, tgt, c;
      bit aging;
      bit fl[4];
      lookup_valid = lv; lookup_vpn = lvpn;
      refill_valid = rv; refill_vpn = rvpn; refill_ppn = rppn; refill_flags = rfl;
      entry_select = sel;
      flush_valid = fv; flush_all = fa; flush_vpn = fvpn;

      hi = -1;
      if (lv) for (int i = 0; i < 4; i++) if (m_valid[i] && m_vpn[i] == lvpn) hi = i;
      e.hit   = (hi >= 0);
      e.miss  = lv && (hi < 0);
      e.ppn   = (hi >= 0) ? m_ppn[hi] : '0;
      e.flags = (hi >= 0) ? m_flags[hi] : '0;
      e.rdone = rv;
      e.fdone = fv;
      if (e.hit || e.miss || e.rdone || e.fdone) exp_q.push_back(e);

      tgt = -1;
      if (rv) begin
         for (int i = 0; i < 4; i++) if (m_valid[i] && m_vpn[i] == rvpn) tgt = i;
         if (tgt < 0) begin
            tgt = 0;
            for (int i = 3; i >= 0; i--) if (sel[i]) tgt = i;
         end
      end
      for (int i = 0; i < 4; i++) fl[i] = fv && (fa || m_vpn[i] == fvpn);
      aging = (m_cycles % AGE_PERIOD) == AGE_PERIOD - 1;
      for (int i = 0; i < 4; i++) begin
         if (i == tgt) begin
            m_vpn[i] = rvpn; m_ppn[i] = rppn; m_flags[i] = rfl;
            m_valid[i] = 1'b1; m_cnt[i] = INIT_CNT;
         end else begin
            c = aging ? m_cnt[i] / 2 : m_cnt[i];
            if (i == hi) c = (c + 1 > CMAX) ? CMAX : c + 1;
            m_cnt[i] = c;
         end
         if (fl[i]) m_valid[i] = 1'b0;
      end
      m_cycles++;

      @(posedge clk);
      @(negedge clk);
      check_entries();
   endtask

   task automatic idle();
      step(0, '0, 0, '0, '0, '0, 4'b0, 0, 0, '0);
   endtask
   task automatic lookup(input logic [VPN_W-1:0] v);
      step(1, v, 0, '0, '0, '0, 4'b0, 0, 0, '0);
   endtask
   task automatic refill(input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p,
                         input logic [7:0] f, input logic [3:0] sel);
      step(0, '0, 1, v, p, f, sel, 0, 0, '0);
   endtask
   task automatic flush(input logic fa, input logic [VPN_W-1:0] v);
      step(0, '0, 0, '0, '0, '0, 4'b0, 1, fa, v);
   endtask

   // monitor: pops one expectation whenever the DUT presents any response
   always @(negedge clk) begin
      resp_t e;
      if (rst_n && (hit || miss || refill_done || flush_done)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_resp: got hit=%b miss=%b rdone=%b fdone=%b expected none",
                     hit, miss, refill_done, flush_done);
         end else begin
            e = exp_q.pop_front();
            if ({hit, miss, hit_ppn, hit_flags, refill_done, flush_done} !==
                {e.hit, e.miss, e.ppn, e.flags, e.rdone, e.fdone}) begin
               errors++;
               $display("FAIL resp: got hit=%b miss=%b ppn=%0h flags=%0h rdone=%b fdone=%b expected hit=%b miss=%b ppn=%0h flags=%0h rdone=%b fdone=%b",
                        hit, miss, hit_ppn, hit_flags, refill_done, flush_done,
                        e.hit, e.miss, e.ppn, e.flags, e.rdone, e.fdone);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      lookup_valid = 0; lookup_vpn = '0; refill_valid = 0; refill_vpn = '0;
      refill_ppn = '0; refill_flags = '0; entry_select = '0;
      flush_valid = 0; flush_all = 0; flush_vpn = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_hit", 64'(hit), 64'd0);
      chk("reset_miss", 64'(miss), 64'd0);
      chk("reset_hit_ppn", 64'(hit_ppn), 64'd0);
      chk("reset_hit_flags", 64'(hit_flags), 64'd0);
      chk("reset_refill_done", 64'(refill_done), 64'd0);
      chk("reset_flush_done", 64'(flush_done), 64'd0);
      check_entries();
      rst_n = 1'b1;

      lookup(27'h1234);
      refill(27'h1234, 44'hABC, 8'hCF, 4'b0100);
      chk("refill_e2_valid", 64'(e2_v), 64'd1);
      chk("refill_e2_count", 64'(e2_c), 64'd1);
      chk("refill_e2_G", 64'(e2_g), 64'd0);
      lookup(27'h1234);
      chk("hit_e2_count", 64'(e2_c), 64'd2);
      refill(27'h1234, 44'h555, 8'hCF, 4'b0001);
      chk("dup_refill_e0_valid", 64'(e0_v), 64'd0);
      lookup(27'h1234);

      repeat (5000) lookup(27'h1234);
      chk("saturated_count", 64'(e2_c), 64'd4095);
      while ((m_cycles % AGE_PERIOD) != AGE_PERIOD - 1) lookup(27'h1234);
      lookup(27'h1234);
      chk("aging_hit_count", 64'(e2_c), 64'd2048);

      flush(1, '0);
      refill(27'h10, 44'h100, 8'h0F, 4'b0001);
      refill(27'h11, 44'h101, 8'h21, 4'b0010);
      refill(27'h12, 44'h102, 8'h0F, 4'b0100);
      refill(27'h13, 44'h103, 8'h0F, 4'b1000);
      chk("fill_e1_G", 64'(e1_g), 64'd1);
      flush(0, 27'h13);
      chk("sel_flush_valids", 64'({e3_v, e2_v, e1_v, e0_v}), 64'b0111);
      flush(1, '0);
      chk("all_flush_valids", 64'({e3_v, e2_v, e1_v, e0_v}), 64'b0000);
      idle();

      for (int n = 0; n < 3000; n++) begin
         logic lv, rv, fv, fa;
         lv = ($urandom_range(0, 9) < 7);
         rv = ($urandom_range(0, 9) < 2);
         fv = ($urandom_range(0, 19) == 0);
         fa = $urandom_range(0, 1) == 1;
         step(lv, 27'($urandom_range(0, 7) + 'h100),
              rv, 27'($urandom_range(0, 7) + 'h100),
              {12'($urandom), 32'($urandom)}, 8'($urandom), 4'($urandom),
              fv, fa, 27'($urandom_range(0, 7) + 'h100));
      end

      flush(1, '0);
      refill(27'h50, 44'h777, 8'h0F, 4'b0001);
      step(1, 27'h50, 1, 27'h60, 44'h888, 8'h0F, 4'b0001, 1, 1, '0);
      chk("collide_hit", 64'(hit), 64'd1);
      chk("collide_refill_done", 64'(refill_done), 64'd1);
      chk("collide_flush_done", 64'(flush_done), 64'd1);
      chk("collide_e0_valid", 64'(e0_v), 64'd0);
      lookup_valid = 0; refill_valid = 0; flush_valid = 0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs",
          64'({hit, miss, refill_done, flush_done, e0_v, e1_v, e2_v, e3_v}), 64'd0);
      chk("async_rst_data", 64'(hit_ppn) | 64'(hit_flags) | 64'(e0_c) | 64'(e1_c)
                          | 64'(e2_c) | 64'(e3_c), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
